uart_rx_frame: RTL

Serial receive engine of the UART: converts the asynchronous `rx` line into parallel characters of 5–8 data bits, 1 stop bit, and optional parity. It samples at 16× oversampling, driven by the shared baud tick, and presents each character with a one-cycle valid pulse plus error flags. It pairs with the transmit path and uses the same `no_of_bits` encoding.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_frame.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, defaults and the no_of_bits decode
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // no_of_bits encoding shared with the transmit path: 00=5 .. 11=8
  function automatic logic [3:0] data_bits(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchronizer for the serial input, resets to idle-high
module uart_rx_sync (
  input  logic clock,
  input  logic reset,
  input  logic rx_i,
  output logic rx_s_o
);

  logic meta_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      rx_s_o <= 1'b1;
    end else begin
      meta_q <= rx_i;
      rx_s_o <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer, 5-8 data bits, 1 stop, oversampled
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_frame import uart_pkg::*; #(
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic [1:0] no_of_bits,
  input  logic       parity_odd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  logic            rx_s;
  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic [1:0]      nbits_q;
  logic [3:0]      n_bits;
  logic            mid_bit;
  logic            last_bit;
  logic [7:0]      char_d;

  uart_rx_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .rx_i   (rx),
    .rx_s_o (rx_s)
  );

  assign n_bits   = data_bits(nbits_q);
  assign mid_bit  = (cnt_q == FULL_M1);
  assign last_bit = (bit_idx_q == 3'(n_bits - 4'd1));
  // Data bits land at the top of the shift register; right-align them.
  assign char_d   = shift_q >> (4'd8 - n_bits);

`ifdef UART_RX_PARITY_EN
  logic parity_odd_q;
  logic par_err_q;
  logic parity_err_q;
  assign parity_err = parity_err_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      nbits_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_odd_q <= 1'b0;
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q      <= START;
            cnt_q        <= '0;
            shift_q      <= '0;
            nbits_q      <= no_of_bits;
`ifdef UART_RX_PARITY_EN
            parity_odd_q <= parity_odd;
            par_err_q    <= 1'b0;
`endif
          end
        end
        START: begin
          if (sample_tick) begin
            if (cnt_q == HALF_M1) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              state_q   <= rx_s ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (mid_bit) begin
              cnt_q     <= '0;
              shift_q   <= {rx_s, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
              if (last_bit) state_q <= PARITY;
`else
              if (last_bit) state_q <= STOP;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sample_tick) begin
            if (mid_bit) begin
              cnt_q     <= '0;
              par_err_q <= ^shift_q ^ rx_s ^ parity_odd_q;
              state_q   <= STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (sample_tick) begin
            if (mid_bit) begin
              cnt_q     <= '0;
              rx_data   <= char_d;
              rx_valid  <= 1'b1;
              frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_err_q;
`endif
              // Leaving at mid-stop re-arms start detection half a bit early.
              state_q   <= rx_s ? IDLE : WAIT_HIGH;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
